dual_port_mem: RTL and testbench
================================

DUAL_PORT_MEM -- requirements
Module: dual_port_mem

Interface
REQ-001 Parameter DEPTH_BYTES, 4096, byte capacity of the array; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter ADDR_W, 32, width of both byte-address buses.
REQ-003 Parameter CLEAR_ON_RESET, 1, when 1 the array is zero-scrubbed after reset; when 0 the block is ready immediately.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 a_req  input  1  port A access request, one per cycle.
REQ-007 a_addr  input  ADDR_W  port A byte address; the access covers bytes addr..addr+3, little-endian.
REQ-008 a_we  input  4  port A byte write enables; bit i writes byte addr+i from a_wdata[8i+7:8i].
REQ-009 a_wdata  input  32  port A write data.
REQ-010 a_rdata  output  32  port A read data, registered.
REQ-011 a_rvalid  output  1  port A response strobe; high for exactly 1 cycle per accepted request.
REQ-012 a_err  output  1  port A out-of-range strobe, same cycle as a_rvalid.
REQ-013 b_req, b_addr, b_we, b_wdata, b_rdata, b_rvalid, b_err: identical to port A.
REQ-014 busy  output  1  high while the scrub is in progress; requests are not accepted.

Function
REQ-015 A request SHALL be accepted when *_req=1 and busy=0; requests seen while busy=1 SHALL be dropped, with no write and no response.
REQ-016 An accepted request SHALL produce *_rvalid=1 in the next cycle, a fixed latency of 1, with or without a write.
REQ-017 *_rdata SHALL return the 4 bytes at addr..addr+3 as held before that cycle's writes, on both ports (read-first).
REQ-018 Writes SHALL commit at the accepting edge, and only for bytes whose *_we bit is set.
REQ-019 Misaligned addresses SHALL be legal; no alignment is enforced.
REQ-020 If addr+3 >= DEPTH_BYTES, the access SHALL perform no write, *_err SHALL be 1 with *_rvalid, and *_rdata SHALL be 0.
REQ-021 Address range checks SHALL use ADDR_W+1-bit arithmetic so that addr+3 does not wrap.
REQ-022 If both ports write the same byte in the same cycle, port B data SHALL win; any non-overlapping bytes from both ports SHALL be written.
REQ-023 Scrub FSM states: CLEAR and READY.
REQ-024 In CLEAR, one aligned word (4 bytes) SHALL be zeroed per cycle, with a word counter running 0..DEPTH_BYTES/4-1.
REQ-025 After the last word the FSM SHALL enter READY and busy SHALL drop in the same cycle.
REQ-026 The scrub SHALL therefore last exactly DEPTH_BYTES/4 cycles.
REQ-027 With CLEAR_ON_RESET=0, the FSM SHALL go directly to READY after reset; array contents are then undefined unless preloaded.
REQ-028 The FSM SHALL stay in READY until the next reset.
REQ-029 The block SHALL hold no outstanding-request state beyond the single response register per port.

Reset
REQ-030 On rst: a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, a_err=b_err=0, word counter=0.
REQ-031 On rst the FSM SHALL go to CLEAR with busy=1 if CLEAR_ON_RESET=1, or to READY with busy=0 otherwise.
REQ-032 Reset asserted mid-scrub SHALL restart the scrub from word 0.
REQ-033 Reset asserted mid-access SHALL suppress the pending response.
REQ-034 The memory array itself SHALL not be reset; only the scrub clears it.

Structure
REQ-035 A shared package mem_pkg SHALL hold WORD_W=32, BE_W=4 and the scrub state enum {CLEAR, READY}.
REQ-036 The scrub counter and FSM SHALL be one sub-module, mem_scrub, with outputs busy, clr_en and clr_addr.
REQ-037 The array SHALL be a single byte-wide storage with three write sources, applied in priority order: scrub, then A, then B (B last, so B wins).

Verification
REQ-038 Reset with DEPTH_BYTES=64 -> busy=1 for exactly 16 cycles, then 0; a read of addr 0 returns 0x00000000.
REQ-039 A writes 0xDEADBEEF at 0x10 with we=4'hF, then B reads 0x10 -> B response one cycle later: rdata=0xDEADBEEF, rvalid=1, err=0.
REQ-040 Same cycle: A writes 0x11223344 at 0x20 with we=4'hF, B writes 0xAABBCCDD at 0x22 with we=4'h3 -> a later read of 0x20 returns 0xCCDD3344.
REQ-041 A reads 0x3D with DEPTH_BYTES=64 -> a_err=1, a_rdata=0; a read of 0x3C returns the prior contents, no err.
REQ-042 A read and B write of 0x00 in the same cycle -> A returns the old value; the next read returns the new value.
REQ-043 rst asserted at scrub cycle 7 -> busy stays high a further 16 cycles after release; a_req during busy -> no a_rvalid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and widths for the dual-port byte memory.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

   localparam int WORD_W = 32;   // data bus width of each port
   localparam int BE_W   = 4;    // byte enables per word

   // Scrub state: CLEAR zeroes the array after reset, READY serves requests.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } scrub_state_t;

endpackage : mem_pkg

// File: rtl/mem_scrub.sv
// Post-reset scrub sequencer: walks every aligned word once, then releases the array.
// Latency: DEPTH_BYTES/4 cycles from reset release to busy low; 0 when CLEAR_ON_RESET=0.
// Backpressure: none; busy tells the owner to refuse port requests while clearing.
//
// Ports: clk, rst (async active-high); busy (registered, high in CLEAR);
//        clr_en/clr_addr: zero the word at index clr_addr this cycle.
module mem_scrub
   import mem_pkg::*;
#(
   parameter int DEPTH_BYTES    = 4096,
   parameter int CLEAR_ON_RESET = 1,
   parameter int CW             = $clog2(DEPTH_BYTES / 4)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          busy,
   output logic          clr_en,
   output logic [CW-1:0] clr_addr
);

   localparam int WORDS = DEPTH_BYTES / 4;

   scrub_state_t  state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         busy  <= (CLEAR_ON_RESET != 0);
         cnt   <= '0;
      end else begin
         case (state)
            CLEAR: begin
               // busy drops on the same edge that clears the last word
               if (cnt == CW'(WORDS - 1)) begin
                  state <= READY;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            end
            READY: begin
               state <= READY;
               busy  <= 1'b0;
            end
            default: begin
               state <= READY;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_en   = (state == CLEAR);
   assign clr_addr = cnt;

endmodule : mem_scrub

// File: rtl/dual_port_mem.sv
// Dual-port byte-addressed memory, 32-bit little-endian unaligned accesses, read-first.
// Latency: 1 cycle, request to *_rvalid, with or without a write.
// Backpressure: none per request; all requests are dropped (no response) while busy.
//
// Ports: clk, rst (async active-high);
//        {a,b}_req/_addr/_we/_wdata: request, byte address, byte enables, write data;
//        {a,b}_rdata/_rvalid/_err: registered response, one-cycle strobe, range error;
//        busy: post-reset scrub in progress.
module dual_port_mem
   import mem_pkg::*;
#(
   parameter int DEPTH_BYTES    = 4096,
   parameter int ADDR_W         = 32,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [BE_W-1:0]   a_we,
   input  logic [WORD_W-1:0] a_wdata,
   output logic [WORD_W-1:0] a_rdata,
   output logic              a_rvalid,
   output logic              a_err,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [BE_W-1:0]   b_we,
   input  logic [WORD_W-1:0] b_wdata,
   output logic [WORD_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic              b_err,
   output logic              busy
);

   localparam int AW = $clog2(DEPTH_BYTES);   // byte index width (ADDR_W must be >= AW)
   localparam int CW = AW - 2;                // word index width

   logic [7:0] mem [DEPTH_BYTES];

   logic          clr_en;
   logic [CW-1:0] clr_addr;

   mem_scrub #(
      .DEPTH_BYTES    (DEPTH_BYTES),
      .CLEAR_ON_RESET (CLEAR_ON_RESET),
      .CW             (CW)
   ) u_scrub (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   // Range check on one extra bit so addr+3 near the top of the address space cannot wrap.
   logic [ADDR_W:0] a_end, b_end;
   logic            a_oob, b_oob;
   logic            a_acc, b_acc;
   logic            a_wr, b_wr;
   logic [AW-1:0]   a_base, b_base;
   logic [AW-1:0]   clr_base;

   assign a_end  = {1'b0, a_addr} + (ADDR_W + 1)'(3);
   assign b_end  = {1'b0, b_addr} + (ADDR_W + 1)'(3);
   assign a_oob  = (a_end >= (ADDR_W + 1)'(DEPTH_BYTES));
   assign b_oob  = (b_end >= (ADDR_W + 1)'(DEPTH_BYTES));
   assign a_acc  = a_req & ~busy;
   assign b_acc  = b_req & ~busy;
   assign a_wr   = a_acc & ~a_oob;
   assign b_wr   = b_acc & ~b_oob;
   assign a_base = a_addr[AW-1:0];
   assign b_base = b_addr[AW-1:0];
   assign clr_base = {clr_addr, 2'b00};

   // Word gather before this edge's writes land, which gives read-first on both ports.
   // Out-of-range indices are masked to zero at the response register.
   logic [WORD_W-1:0] a_word, b_word;

   always_comb begin
      a_word = '0;
      b_word = '0;
      for (int i = 0; i < BE_W; i++) begin
         a_word[8*i +: 8] = mem[a_base + AW'(i)];
         b_word[8*i +: 8] = mem[b_base + AW'(i)];
      end
   end

   // Array is never reset. Later assignments win, so the order is scrub, A, then B.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         for (int i = 0; i < BE_W; i++)
            mem[clr_base + AW'(i)] <= 8'h00;
      end
      if (a_wr) begin
         for (int i = 0; i < BE_W; i++)
            if (a_we[i]) mem[a_base + AW'(i)] <= a_wdata[8*i +: 8];
      end
      if (b_wr) begin
         for (int i = 0; i < BE_W; i++)
            if (b_we[i]) mem[b_base + AW'(i)] <= b_wdata[8*i +: 8];
      end
   end

   // Response registers: the only per-port state; reset kills any response in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rdata  <= '0;
         a_rvalid <= 1'b0;
         a_err    <= 1'b0;
         b_rdata  <= '0;
         b_rvalid <= 1'b0;
         b_err    <= 1'b0;
      end else begin
         a_rvalid <= a_acc;
         a_err    <= a_acc & a_oob;
         b_rvalid <= b_acc;
         b_err    <= b_acc & b_oob;
         if (a_acc) a_rdata <= a_oob ? '0 : a_word;
         if (b_acc) b_rdata <= b_oob ? '0 : b_word;
      end
   end

endmodule : dual_port_mem

// File: tb/tb_dual_port_mem.sv
// Directed self-checking bench for dual_port_mem with a 64-byte array.
// Latency: responses are sampled on the falling edge after the accepting edge.
// Backpressure: checks that requests during the scrub produce no response.
module tb_dual_port_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req = 1'b0, b_req = 1'b0;
   logic [31:0] a_addr = '0, b_addr = '0;
   logic [3:0]  a_we = '0, b_we = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic [31:0] a_rdata, b_rdata;
   logic        a_rvalid, b_rvalid, a_err, b_err, busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dual_port_mem #(
      .DEPTH_BYTES    (64),
      .ADDR_W         (32),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a_req    (a_req),
      .a_addr   (a_addr),
      .a_we     (a_we),
      .a_wdata  (a_wdata),
      .a_rdata  (a_rdata),
      .a_rvalid (a_rvalid),
      .a_err    (a_err),
      .b_req    (b_req),
      .b_addr   (b_addr),
      .b_we     (b_we),
      .b_wdata  (b_wdata),
      .b_rdata  (b_rdata),
      .b_rvalid (b_rvalid),
      .b_err    (b_err),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; drives one cycle of requests and returns at the
   // next falling edge, where the responses to those requests are visible.
   task automatic cyc(input logic ar, input logic [31:0] aa, input logic [3:0] awe,
                      input logic [31:0] awd, input logic br, input logic [31:0] ba,
                      input logic [3:0] bwe, input logic [31:0] bwd);
      a_req = ar; a_addr = aa; a_we = awe; a_wdata = awd;
      b_req = br; b_addr = ba; b_we = bwe; b_wdata = bwd;
      @(negedge clk);
      a_req = 1'b0; b_req = 1'b0; a_we = '0; b_we = '0;
   endtask

   // Counts cycles with busy high, starting at a falling edge; bounded.
   task automatic count_busy(output int n, output logic saw_rvalid);
      n = 0;
      saw_rvalid = 1'b0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
         if (a_rvalid) saw_rvalid = 1'b1;
      end
   endtask

   int   nb;
   logic sv;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
      check("rst_a_rdata", a_rdata, 32'h0);
      check("rst_b_rvalid", {31'b0, b_rvalid}, 32'd0);
      check("rst_err", {30'b0, a_err, b_err}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd1);

      // scrub length: 64 bytes -> 16 words
      rst = 1'b0;
      count_busy(nb, sv);
      check("scrub_cycles", nb, 32'd16);
      check("scrub_busy_low", {31'b0, busy}, 32'd0);

      // read of a scrubbed word
      cyc(1, 32'h00, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
      check("rd0_rvalid", {31'b0, a_rvalid}, 32'd1);
      check("rd0_rdata", a_rdata, 32'h0000_0000);
      check("rd0_err", {31'b0, a_err}, 32'd0);

      // A write then B read
      cyc(1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0, 4'h0, 32'h0);
      check("wr_rvalid", {31'b0, a_rvalid}, 32'd1);
      cyc(0, 32'h0, 4'h0, 32'h0, 1, 32'h10, 4'h0, 32'h0);
      check("b_rd10_rdata", b_rdata, 32'hDEADBEEF);
      check("b_rd10_rvalid", {31'b0, b_rvalid}, 32'd1);
      check("b_rd10_err", {31'b0, b_err}, 32'd0);
      @(negedge clk);
      check("b_rvalid_one_cycle", {31'b0, b_rvalid}, 32'd0);

      // overlapping same-cycle writes: B wins the shared bytes
      cyc(1, 32'h20, 4'hF, 32'h11223344, 1, 32'h22, 4'h3, 32'hAABBCCDD);
      check("ovl_b_readfirst", b_rdata, 32'h0000_0000);
      cyc(1, 32'h20, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
      check("ovl_rd20", a_rdata, 32'hCCDD3344);

      // top-of-array boundary and no-wrap range check
      cyc(0, 32'h0, 4'h0, 32'h0, 1, 32'h3C, 4'hF, 32'h55667788);
      cyc(1, 32'h3D, 4'hF, 32'hFFFFFFFF, 0, 32'h0, 4'h0, 32'h0);
      check("oob3d_err", {31'b0, a_err}, 32'd1);
      check("oob3d_rdata", a_rdata, 32'h0);
      check("oob3d_rvalid", {31'b0, a_rvalid}, 32'd1);
      cyc(1, 32'hFFFFFFFE, 4'hF, 32'h99999999, 0, 32'h0, 4'h0, 32'h0);
      check("oob_wrap_err", {31'b0, a_err}, 32'd1);
      cyc(1, 32'h3C, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
      check("rd3c_rdata", a_rdata, 32'h55667788);
      check("rd3c_err", {31'b0, a_err}, 32'd0);

      // misaligned write and partial byte enables
      cyc(1, 32'h05, 4'hF, 32'hA1B2C3D4, 1, 32'h30, 4'h5, 32'h12345678);
      cyc(1, 32'h04, 4'h0, 32'h0, 1, 32'h08, 4'h0, 32'h0);
      check("mis_rd04", a_rdata, 32'hB2C3D400);
      check("mis_rd08", b_rdata, 32'h000000A1);
      cyc(1, 32'h30, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
      check("be_rd30", a_rdata, 32'h00340078);

      // read-first across ports
      cyc(1, 32'h00, 4'h0, 32'h0, 1, 32'h00, 4'hF, 32'hCAFEF00D);
      check("rf_old", a_rdata, 32'h0000_0000);
      cyc(1, 32'h00, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
      check("rf_new", a_rdata, 32'hCAFEF00D);

      // reset mid-access suppresses the response
      a_req = 1'b1; a_addr = 32'h10;
      @(posedge clk);
      #2 rst = 1'b1; a_req = 1'b0;
      @(negedge clk);
      check("rst_mid_rvalid", {31'b0, a_rvalid}, 32'd0);
      check("rst_mid_busy", {31'b0, busy}, 32'd1);

      // reset at scrub cycle 7 restarts the scrub; requests during busy are dropped
      @(negedge clk);
      rst = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a_req = 1'b1; a_addr = 32'h10; a_we = 4'hF; a_wdata = 32'h12121212;
      count_busy(nb, sv);
      a_req = 1'b0; a_we = 4'h0;
      check("rescrub_cycles", nb, 32'd16);
      check("busy_no_rvalid", {31'b0, sv}, 32'd0);
      check("busy_end_rvalid", {31'b0, a_rvalid}, 32'd0);
      cyc(1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
      check("rescrub_rd10", a_rdata, 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute backstop so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

endmodule : tb_dual_port_mem
